// File: rtl/spi_target_if.sv
// SPI target bus bundle.
// Carries the serial pins (sck/cs_n/mosi in, miso/miso_oe out) together with the
// fabric side of the responder (tx_data in, rx_data/rx_valid/frame_error/busy out).
//   slave  : the spi_target responder
//   master : whoever drives the pins and consumes the received frames
interface spi_target_if #(
  parameter int unsigned SIZE = 40
);
  logic            sck_in;
  logic            cs_n_in;
  logic            mosi_in;
  logic            miso_out;
  logic            miso_oe_out;
  logic [SIZE-1:0] tx_data_in;
  logic [SIZE-1:0] rx_data_out;
  logic            rx_valid_out;
  logic            frame_error_out;
  logic            busy_out;

  modport slave (
    input  sck_in,
    input  cs_n_in,
    input  mosi_in,
    input  tx_data_in,
    output miso_out,
    output miso_oe_out,
    output rx_data_out,
    output rx_valid_out,
    output frame_error_out,
    output busy_out
  );

  modport master (
    output sck_in,
    output cs_n_in,
    output mosi_in,
    output tx_data_in,
    input  miso_out,
    input  miso_oe_out,
    input  rx_data_out,
    input  rx_valid_out,
    input  frame_error_out,
    input  busy_out
  );
endinterface

// File: rtl/spi_target.sv
// SPI responder (mode 3: CPOL=1, CPHA=1, MSB first, fixed SIZE-bit frames).
// Fully oversampled in clk_in, which must run at least 8x the SCK rate.
// Ports:
//   clk_in      : peripheral clock
//   reset_n_in  : asynchronous active-low reset
//   bus         : spi_target_if.slave
//                 sck_in/cs_n_in/mosi_in   asynchronous pins from the initiator
//                 miso_out/miso_oe_out     reply data and its output enable
//                 tx_data_in               reply frame, captured when CS asserts
//                 rx_data_out              last frame received with exactly SIZE bits
//                 rx_valid_out             1-cycle strobe, rx_data_out updated
//                 frame_error_out          1-cycle strobe, frame ended with wrong bit count
//                 busy_out                 frame in progress
module spi_target #(
  parameter int unsigned SIZE = 40
) (
  input logic         clk_in,
  input logic         reset_n_in,
  spi_target_if.slave bus
);

  localparam int unsigned CNT_WIDTH = $clog2(SIZE + 1);
  localparam logic [CNT_WIDTH-1:0] CntFull = CNT_WIDTH'(SIZE);
  localparam logic [CNT_WIDTH-1:0] CntSat  = CNT_WIDTH'(SIZE + 1);

  typedef enum logic [1:0] {
    StIdleWait,
    StIdle,
    StActive
  } state_e;

  // Synchronizers: meta -> sync, plus a prev stage for edge detection on sck/cs.
  logic sck_meta_q, sck_sync_q, sck_prev_q;
  logic cs_meta_q, cs_sync_q, cs_prev_q;
  logic mosi_meta_q, mosi_sync_q;

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      sck_meta_q  <= 1'b1;
      sck_sync_q  <= 1'b1;
      sck_prev_q  <= 1'b1;
      cs_meta_q   <= 1'b1;
      cs_sync_q   <= 1'b1;
      cs_prev_q   <= 1'b1;
      mosi_meta_q <= 1'b0;
      mosi_sync_q <= 1'b0;
    end else begin
      sck_meta_q  <= bus.sck_in;
      sck_sync_q  <= sck_meta_q;
      sck_prev_q  <= sck_sync_q;
      cs_meta_q   <= bus.cs_n_in;
      cs_sync_q   <= cs_meta_q;
      cs_prev_q   <= cs_sync_q;
      mosi_meta_q <= bus.mosi_in;
      mosi_sync_q <= mosi_meta_q;
    end
  end

  logic sck_rise, sck_fall, cs_fall, cs_rise;

  assign sck_rise = sck_sync_q & ~sck_prev_q;
  assign sck_fall = ~sck_sync_q & sck_prev_q;
  assign cs_fall  = ~cs_sync_q & cs_prev_q;
  assign cs_rise  = cs_sync_q & ~cs_prev_q;

  // Frame state
  state_e               state_q, state_d;
  logic [1:0]           settle_q, settle_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic [SIZE-1:0]      tx_shift_q, tx_shift_d;
  logic [SIZE-1:0]      rx_shift_q, rx_shift_d;
  logic                 miso_q, miso_d;
  logic                 miso_oe_q, miso_oe_d;
  logic                 busy_q, busy_d;
  logic                 end_ok_q, end_ok_d;
  logic                 end_err_q, end_err_d;

  always_comb begin
    state_d    = state_q;
    settle_d   = settle_q;
    count_d    = count_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    miso_d     = miso_q;
    miso_oe_d  = miso_oe_q;
    busy_d     = busy_q;
    end_ok_d   = 1'b0;
    end_err_d  = 1'b0;

    unique case (state_q)
      // The synchronizer stages reset to idle levels, so their contents only
      // reflect the real pins after three clocks. Let them refill before trusting
      // cs_n high; otherwise a frame still running at reset release would be
      // picked up half-way through.
      StIdleWait: begin
        if (settle_q != 2'd3) begin
          settle_d = settle_q + 2'd1;
        end else if (cs_sync_q) begin
          state_d = StIdle;
        end
      end

      StIdle: begin
        if (cs_fall) begin
          tx_shift_d = bus.tx_data_in;
          count_d    = '0;
          miso_d     = bus.tx_data_in[SIZE-1];
          miso_oe_d  = 1'b1;
          busy_d     = 1'b1;
          state_d    = StActive;
        end
      end

      StActive: begin
        // cs_rise wins over a coincident sck edge; that edge is dropped.
        if (cs_rise) begin
          miso_d    = 1'b0;
          miso_oe_d = 1'b0;
          busy_d    = 1'b0;
          state_d   = StIdle;
          if (count_q == CntFull) begin
            end_ok_d = 1'b1;
          end else begin
            end_err_d = 1'b1;
          end
        end else if (sck_fall) begin
          // The first falling edge precedes the first sample; the MSB is already
          // on the line from CS assertion.
          if (count_q != '0) begin
            tx_shift_d = {tx_shift_q[SIZE-2:0], 1'b0};
            miso_d     = tx_shift_q[SIZE-2];
          end
        end else if (sck_rise) begin
          rx_shift_d = {rx_shift_q[SIZE-2:0], mosi_sync_q};
          if (count_q != CntSat) begin
            count_d = count_q + CNT_WIDTH'(1);
          end
        end
      end

      default: state_d = StIdleWait;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q    <= StIdleWait;
      settle_q   <= '0;
      count_q    <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      miso_q     <= 1'b0;
      miso_oe_q  <= 1'b0;
      busy_q     <= 1'b0;
      end_ok_q   <= 1'b0;
      end_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      settle_q   <= settle_d;
      count_q    <= count_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      miso_q     <= miso_d;
      miso_oe_q  <= miso_oe_d;
      busy_q     <= busy_d;
      end_ok_q   <= end_ok_d;
      end_err_q  <= end_err_d;
    end
  end

  // Result register. rx_shift is frozen once back in idle, so it can be copied
  // one cycle after the end-of-frame decision.
  logic [SIZE-1:0] rx_data_q, rx_data_d;
  logic            rx_valid_q, frame_error_q;

  always_comb begin
    rx_data_d = rx_data_q;
    if (end_ok_q) begin
      rx_data_d = rx_shift_q;
    end
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= end_ok_q;
      frame_error_q <= end_err_q;
    end
  end

  assign bus.miso_out        = miso_q;
  assign bus.miso_oe_out     = miso_oe_q;
  assign bus.busy_out        = busy_q;
  assign bus.rx_data_out     = rx_data_q;
  assign bus.rx_valid_out    = rx_valid_q;
  assign bus.frame_error_out = frame_error_q;

endmodule

// File: tb/tb_spi_target.sv
module tb_spi_target;

  localparam int unsigned SIZE = 40;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  spi_target_if #(.SIZE(SIZE)) bus ();

  spi_target #(.SIZE(SIZE)) u_dut (
    .clk_in     (clk),
    .reset_n_in (rst_n),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected end-of-frame events, pushed when the bench raises CS.
  typedef struct {
    bit              ok;
    logic [SIZE-1:0] data;
    int              cs_cyc;
  } exp_t;

  exp_t            exp_q[$];
  logic [SIZE-1:0] model_rx;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      model_rx = '0;
      check("reset_outputs",
            {bus.rx_data_out, bus.miso_out, bus.miso_oe_out, bus.rx_valid_out,
             bus.frame_error_out, bus.busy_out}, 64'd0);
    end else begin
      if (bus.rx_valid_out || bus.frame_error_out) begin
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", {62'd0, bus.rx_valid_out, bus.frame_error_out}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("strobe_kind", {62'd0, bus.rx_valid_out, bus.frame_error_out},
                e.ok ? 64'd2 : 64'd1);
          check("strobe_latency", 64'(cyc - e.cs_cyc), 64'd4);
          if (e.ok) model_rx = e.data;
        end
      end
      check("rx_data", 64'(bus.rx_data_out), 64'(model_rx));
      check("oe_vs_busy", 64'(bus.miso_oe_out), 64'(bus.busy_out));
    end
  end

  // One mode-3 frame: nbits from the low end of bits, MSB first. SCK = clk/8.
  task automatic run_frame(input logic [63:0] bits, input int nbits, input logic [SIZE-1:0] tx,
                           input int chg_at, input logic [SIZE-1:0] tx_new, input int gap,
                           output logic [SIZE-1:0] miso_word);
    logic [SIZE-1:0] rx_exp;
    logic            b;
    exp_t            e;
    rx_exp    = '0;
    miso_word = '0;
    bus.tx_data_in = tx;
    bus.cs_n_in    = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      b = bits[nbits-1-i];
      bus.sck_in  = 1'b0;
      bus.mosi_in = b;
      repeat (4) @(negedge clk);
      if (i == 0) check("busy_in_frame", 64'(bus.busy_out), 64'd1);
      miso_word  = {miso_word[SIZE-2:0], bus.miso_out};
      rx_exp     = {rx_exp[SIZE-2:0], b};
      bus.sck_in = 1'b1;
      repeat (4) @(negedge clk);
      if (i == chg_at) bus.tx_data_in = tx_new;
    end
    bus.cs_n_in = 1'b1;
    e.ok     = (nbits == SIZE);
    e.data   = rx_exp;
    e.cs_cyc = cyc;
    exp_q.push_back(e);
    repeat (6) @(negedge clk);
    check("strobe_seen", 64'(exp_q.size()), 64'd0);
    check("busy_gap", 64'(bus.busy_out), 64'd0);
    repeat (gap - 6) @(negedge clk);
  endtask

  initial begin
    logic [SIZE-1:0] w;
    bus.sck_in     = 1'b1;
    bus.cs_n_in    = 1'b1;
    bus.mosi_in    = 1'b0;
    bus.tx_data_in = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (5) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // Good frame
    run_frame(64'hA5_DEADBEEF, 40, 40'h3C_12345678, -1, '0, 16, w);
    check("frame1_rx", 64'(bus.rx_data_out), 64'hA5_DEADBEEF);
    check("frame1_miso", 64'(w), 64'h3C_12345678);

    // Short and long frames keep the previous data
    run_frame(64'h12_3456789A, 39, 40'h0, -1, '0, 16, w);
    check("short_keeps_rx", 64'(bus.rx_data_out), 64'hA5_DEADBEEF);
    run_frame(64'h1_5A5A5A5A5A, 41, 40'h0, -1, '0, 16, w);
    check("long_keeps_rx", 64'(bus.rx_data_out), 64'hA5_DEADBEEF);

    // CS pulse with no SCK
    run_frame(64'h0, 0, 40'h0, -1, '0, 16, w);

    // tx_data_in changes mid-frame must not reach MISO
    run_frame(64'h12_3456789A, 40, 40'hFF_FFFFFFFF, 5, 40'h0, 16, w);
    check("tx_change_miso", 64'(w), 64'hFF_FFFFFFFF);

    // Back-to-back with a 2-SCK-period gap
    run_frame(64'h01_02030405, 40, 40'h81_18244281, -1, '0, 16, w);
    check("b2b_0_miso", 64'(w), 64'h81_18244281);
    run_frame(64'hFA_FBFCFDFE, 40, 40'h00_0000FFFF, -1, '0, 16, w);
    check("b2b_1_rx", 64'(bus.rx_data_out), 64'hFA_FBFCFDFE);
    check("b2b_1_miso", 64'(w), 64'h00_0000FFFF);

    // Reset in the middle of a frame, released while CS is still low
    bus.tx_data_in = 40'h55_55555555;
    bus.cs_n_in    = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      bus.sck_in  = 1'b0;
      bus.mosi_in = 1'b1;
      repeat (4) @(negedge clk);
      bus.sck_in = 1'b1;
      repeat (4) @(negedge clk);
    end
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.sck_in  = 1'b0;
      bus.mosi_in = 1'b1;
      repeat (4) @(negedge clk);
      check("oe_after_rst", 64'(bus.miso_oe_out), 64'd0);
      bus.sck_in = 1'b1;
      repeat (4) @(negedge clk);
    end
    bus.cs_n_in = 1'b1;
    repeat (16) @(negedge clk);
    check("rx_after_rst", 64'(bus.rx_data_out), 64'd0);
    run_frame(64'h00_00000001, 40, 40'hC3_A5965A3C, -1, '0, 16, w);
    check("post_rst_rx", 64'(bus.rx_data_out), 64'h00_00000001);
    check("post_rst_miso", 64'(w), 64'hC3_A5965A3C);

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/spi_target.md
Name: spi_target

Overview:
- SPI responder, the far end of the existing `spi` initiator.
- Provides a target-side model of a stepper driver register interface for simulation. Also lets an external host on the gn SPI pins talk to the FPGA.
- Runs fully oversampled in the peripheral_clk domain. Mode 3 (CPOL=1, CPHA=1), MSB first, fixed-length frames.
- Received frames go to the fabric with a one-cycle valid strobe. The reply frame is latched from the fabric when chip select asserts.

Parameters:
- SIZE, 40, frame length in bits (8-bit address + 32-bit data).
- CNT_WIDTH, $clog2(SIZE+1), width of the bit counter. Derived; not overridden.

Ports:
- clk_in  input  1  system clock, peripheral_clk; must be ≥ 8× SCK frequency
- reset_n_in  input  1  asynchronous active-low reset
- sck_in  input  1  SPI clock from initiator, asynchronous
- cs_n_in  input  1  chip select, active low, asynchronous
- mosi_in  input  1  serial data from initiator, asynchronous
- miso_out  output  1  serial data to initiator
- miso_oe_out  output  1  MISO output enable; 1 while frame active
- tx_data_in  input  SIZE  reply frame, sampled at CS assertion
- rx_data_out  output  SIZE  last correctly sized received frame
- rx_valid_out  output  1  one-cycle strobe: rx_data_out updated
- frame_error_out  output  1  one-cycle strobe: frame ended with bit count ≠ SIZE
- busy_out  output  1  frame in progress

Behaviour:
- Reset (asynchronous, active low):
  - miso_out=0, miso_oe_out=0, rx_data_out=0, rx_valid_out=0, frame_error_out=0, busy_out=0.
  - Synchronizers reset to idle levels (sck=1, cs_n=1).
  - Shift registers and counter are 0. State is IDLE_WAIT.
- Input synchronization:
  - sck_in, cs_n_in and mosi_in each pass a 2-FF synchronizer.
  - A third register provides edge detect: sck_rise, sck_fall, cs_fall, cs_rise.
  - MOSI is sampled from its synchronized copy aligned with sck (same stage depth).
- States:
  - IDLE_WAIT: entered after reset. Ignores everything until synchronized cs_n is seen high for ≥1 cycle, then goes to IDLE. A frame already in progress at reset release is dropped.
  - IDLE: on cs_fall:
    - tx_shift ← tx_data_in; count ← 0.
    - miso_oe_out=1, busy_out=1. miso_out ← tx_data_in[SIZE-1] on the same edge.
    - Go to ACTIVE.
  - ACTIVE:
    - On sck_fall: if count>0, tx_shift shifts left by one, zero-filled, and miso_out ← new tx_shift[SIZE-1]. The first falling edge (count=0) leaves the MSB in place.
    - On sck_rise: rx_shift ← {rx_shift[SIZE-2:0], mosi}. count increments, saturating at SIZE+1.
    - On cs_rise: go to IDLE; miso_oe_out=0, miso_out=0, busy_out=0.
      - If count==SIZE: rx_data_out ← rx_shift and rx_valid_out=1 for exactly one cycle.
      - Otherwise: frame_error_out=1 for one cycle and rx_data_out is unchanged.
- Latency:
  - miso_out changes 3 clk_in cycles after an SCK pin falling edge.
  - rx_valid_out asserts 4 clk_in cycles after the CS pin rising edge (3 sync/edge + 1 output register).
- Simultaneous events: cs_rise in the same cycle as an sck edge takes priority, and that sck edge is ignored.
- Changes to tx_data_in during ACTIVE have no effect on the current frame.
- Bits beyond SIZE keep shifting rx_shift, but the frame is flagged as an error.
- A zero-bit frame (CS pulse with no SCK) gives frame_error_out.
- SCK edges while CS is deasserted are ignored.
- No back-pressure: rx_data_out is overwritten by the next valid frame regardless of whether it was consumed.

Test Plan:
- Reset then a 40-bit mode-3 frame:
  - MOSI = 0xA5_DEADBEEF, tx_data_in = 0x3C_12345678, SCK = clk_in/8.
  - Required: rx_valid_out pulses once, rx_data_out = 0xA5DEADBEEF.
  - Required: bits sampled on MISO at SCK rising edges = 0x3C12345678.
- Short frame (39 clocks) after a good frame:
  - Required: frame_error_out pulses once, no rx_valid_out, rx_data_out keeps its previous value.
- Long frame (41 clocks): frame_error_out pulses once, no rx_valid_out.
- Reset asserted mid-frame (after 20 bits) and released with cs_n still low:
  - Required: no strobes, miso_oe_out=0 until CS goes high.
  - Required: the following full frame (MOSI = 0x0000000001) is received correctly.
- tx_data_in changed from 0xFFFFFFFFFF to 0x0000000000 after bit 5:
  - Required: MISO still delivers all ones for the whole frame.
- Back-to-back frames with a 2-SCK-period CS-high gap:
  - Frames 0x0102030405 then 0xFAFBFCFDFE.
  - Required: two rx_valid_out pulses with the matching data; busy_out drops between them.
